output_pack: RTL and testbench

// - Final HCORDIC pipeline stage, at the opposite end from special-case unpacking: takes an internal result
//   (idle code, 36-bit z, 32-bit s) and packs it into IEEE-754 single with normalisation and RNE rounding.
// - Multi-cycle: one left-shift per clock; valid/ready handshake on both sides; instruction tag travels with the result.

---
 rtl/output_pack_pkg.sv | 20 ++
 rtl/round_nearest_even.sv | 35 +++
 rtl/output_pack.sv | 147 ++++++++++++++
 tb/tb_output_pack.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/output_pack_pkg.sv
// Shared definitions for the HCORDIC output packing stage: idle codes, FSM states, field widths.
package output_pack_pkg;

    localparam int EXP_W = 10;
    localparam logic [22:0] QNAN_MANT = 23'h400000;

    typedef enum logic [1:0] {
        NO_IDLE     = 2'b00,
        ALLIGN_IDLE = 2'b01,
        PUT_IDLE    = 2'b10
    } idle_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_NORM  = 2'b01,
        S_ROUND = 2'b10,
        S_OUT   = 2'b11
    } state_e;

endpackage

// File: rtl/round_nearest_even.sv
// Combinational round-to-nearest-even of a normalised mantissa carrying guard/round/sticky in its low bits.
module round_nearest_even
    import output_pack_pkg::*;
#(
    parameter int MANT_W = 27
) (
    input  logic [MANT_W-1:0] i_mant,
    input  logic [EXP_W-1:0]  i_exp,
    output logic [MANT_W-4:0] o_keep,
    output logic [EXP_W-1:0]  o_exp,
    output logic              o_inexact
);

    localparam int KW = MANT_W - 3;

    logic [KW-1:0] w_keep;
    logic          w_g;
    logic          w_r;
    logic          w_s;
    logic          w_up;
    logic [KW:0]   w_sum;

    assign w_keep = i_mant[MANT_W-1:3];
    assign w_g    = i_mant[2];
    assign w_r    = i_mant[1];
    assign w_s    = i_mant[0];
    assign w_up   = w_g & (w_r | w_s | w_keep[0]);
    assign w_sum  = {1'b0, w_keep} + {{KW{1'b0}}, w_up};

    // A carry out of the kept field renormalises to 1.000... with the exponent bumped.
    assign o_keep    = w_sum[KW] ? {1'b1, {(KW-1){1'b0}}} : w_sum[KW-1:0];
    assign o_exp     = i_exp + {{(EXP_W-1){1'b0}}, w_sum[KW]};
    assign o_inexact = w_g | w_r | w_s;

endmodule

// File: rtl/output_pack.sv
// HCORDIC final stage: normalises (one shift per clock), RNE-rounds and packs the internal result to IEEE-754 single.
module output_pack
    import output_pack_pkg::*;
#(
    parameter int TAG_W  = 8,
    parameter int MANT_W = 27
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        idle_Pack,
    input  logic [MANT_W+8:0] zin_Pack,
    input  logic [31:0]       sin_Pack,
    input  logic [TAG_W-1:0]  InsTag_Pack,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       zout_Pack,
    output logic [TAG_W-1:0]  InsTagout_Pack,
    output logic [2:0]        flags_Pack,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e r_state;
    state_e w_state_nxt;

    logic              r_sign;
    logic [MANT_W-1:0] r_mant;
    logic [EXP_W-1:0]  r_exp;
    logic [TAG_W-1:0]  r_tag;
    logic [31:0]       r_zout;
    logic [TAG_W-1:0]  r_tagout;
    logic [2:0]        r_flags;

    logic              w_sign_in;
    logic [7:0]        w_exp_in;
    logic [MANT_W-1:0] w_mant_in;
    logic              w_accept;
    logic              w_put;
    logic              w_nan_inf;
    logic              w_zero;
    logic              w_special;
    logic [31:0]       w_special_z;
    logic [2:0]        w_special_flags;
    logic              w_shift;

    logic [MANT_W-4:0] w_keep;
    logic [EXP_W-1:0]  w_rne_exp;
    logic              w_inexact;
    logic              w_ovf;
    logic [7:0]        w_expfield;
    logic [31:0]       w_round_z;

    assign w_sign_in = zin_Pack[MANT_W+8];
    assign w_exp_in  = zin_Pack[MANT_W+7:MANT_W];
    assign w_mant_in = zin_Pack[MANT_W-1:0];

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_put     = (idle_Pack == PUT_IDLE);
    assign w_nan_inf = (idle_Pack == ALLIGN_IDLE) && (w_exp_in == 8'hFF);
    assign w_zero    = !w_put && !w_nan_inf && (w_mant_in == '0);
    assign w_special = w_put || w_nan_inf || w_zero;

    always_comb begin
        w_special_z = {w_sign_in, 31'd0};
        if (w_put)
            w_special_z = sin_Pack;
        else if (w_nan_inf)
            w_special_z = {w_sign_in, 8'hFF, (w_mant_in != '0) ? QNAN_MANT : 23'd0};
    end

    assign w_special_flags = {w_nan_inf && (w_mant_in != '0), 2'b00};
    assign w_shift         = !r_mant[MANT_W-1] && (r_exp > 10'd1);

    round_nearest_even #(.MANT_W(MANT_W)) u_rne (
        .i_mant    (r_mant),
        .i_exp     (r_exp),
        .o_keep    (w_keep),
        .o_exp     (w_rne_exp),
        .o_inexact (w_inexact)
    );

    // A result without the hidden bit is denormal and gets a zero exponent field.
    assign w_ovf      = (w_rne_exp >= 10'd255);
    assign w_expfield = w_keep[MANT_W-4] ? w_rne_exp[7:0] : 8'd0;
    assign w_round_z  = w_ovf ? {r_sign, 8'hFF, 23'd0} : {r_sign, w_expfield, w_keep[MANT_W-5:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_OUT : S_NORM;
            S_NORM:  if (!w_shift) w_state_nxt = S_ROUND;
            S_ROUND: w_state_nxt = S_OUT;
            S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_OUT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sign   <= 1'b0;
            r_mant   <= '0;
            r_exp    <= '0;
            r_tag    <= '0;
            r_zout   <= '0;
            r_tagout <= '0;
            r_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_sign <= w_sign_in;
                r_mant <= w_mant_in;
                r_exp  <= (w_exp_in == 8'd0) ? 10'd1 : {2'b00, w_exp_in};
                r_tag  <= InsTag_Pack;
                if (w_special) begin
                    r_zout   <= w_special_z;
                    r_flags  <= w_special_flags;
                    r_tagout <= InsTag_Pack;
                end
            end
            if ((r_state == S_NORM) && w_shift) begin
                r_mant <= {r_mant[MANT_W-2:0], 1'b0};
                r_exp  <= r_exp - 10'd1;
            end
            if (r_state == S_ROUND) begin
                r_zout   <= w_round_z;
                r_flags  <= {1'b0, w_ovf, w_ovf | w_inexact};
                r_tagout <= r_tag;
            end
        end
    end

    assign zout_Pack      = r_zout;
    assign InsTagout_Pack = r_tagout;
    assign flags_Pack     = r_flags;

endmodule

// File: tb/tb_output_pack.sv
// Directed-vector bench for output_pack: special paths, normalise/round cases, backpressure and mid-operation reset.
module tb_output_pack;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  idle_Pack = 2'b00;
    logic [35:0] zin_Pack = '0;
    logic [31:0] sin_Pack = '0;
    logic [7:0]  InsTag_Pack = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] zout_Pack;
    logic [7:0]  InsTagout_Pack;
    logic [2:0]  flags_Pack;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    output_pack #(.TAG_W(8), .MANT_W(27)) dut (
        .clock          (clock),
        .reset          (reset),
        .idle_Pack      (idle_Pack),
        .zin_Pack       (zin_Pack),
        .sin_Pack       (sin_Pack),
        .InsTag_Pack    (InsTag_Pack),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .zout_Pack      (zout_Pack),
        .InsTagout_Pack (InsTagout_Pack),
        .flags_Pack     (flags_Pack),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one beat, measure edges beyond the accept edge until out_valid, then check the packed result.
    task automatic run(input string name, input logic [1:0] idle, input logic [35:0] z,
                       input logic [31:0] s, input logic [7:0] tag,
                       input logic [31:0] exp_z, input logic [2:0] exp_f, input int exp_lat);
        int lat;
        @(negedge clock);
        idle_Pack   = idle;
        zin_Pack    = z;
        sin_Pack    = s;
        InsTag_Pack = tag;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_zout"}, zout_Pack, exp_z);
        chk({name, "_tag"}, {24'd0, InsTagout_Pack}, {24'd0, tag});
        chk({name, "_flags"}, {29'd0, flags_Pack}, {29'd0, exp_f});
    endtask

    task automatic drain(input string name);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk({name, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_zout", zout_Pack, 32'd0);
        chk("rst_tag", {24'd0, InsTagout_Pack}, 32'd0);
        chk("rst_flags", {29'd0, flags_Pack}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run("put", 2'b10, 36'h0, 32'h3F800000, 8'h5A, 32'h3F800000, 3'b000, 0);

        // Held output must not move and new beats must be refused while downstream stalls.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            idle_Pack   = 2'b10;
            sin_Pack    = 32'hDEADBEEF;
            InsTag_Pack = 8'hA5;
            in_valid    = 1'b1;
            chk("bp_zout", zout_Pack, 32'h3F800000);
            chk("bp_tag", {24'd0, InsTagout_Pack}, 32'h5A);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clock);
        in_valid = 1'b0;
        drain("put");

        run("nan", 2'b01, {1'b1, 8'd255, 1'b1, 26'd0}, 32'h0, 8'h11, 32'hFFC00000, 3'b100, 0);
        drain("nan");
        run("inf", 2'b01, {1'b0, 8'd255, 27'd0}, 32'h0, 8'h12, 32'h7F800000, 3'b000, 0);
        drain("inf");
        run("one", 2'b00, {1'b0, 8'd127, 27'h4000000}, 32'h0, 8'h13, 32'h3F800000, 3'b000, 2);
        drain("one");
        run("shift3", 2'b00, {1'b0, 8'd130, 27'h0800000}, 32'h0, 8'h14, 32'h3F800000, 3'b000, 5);
        drain("shift3");
        run("carry", 2'b00, {1'b0, 8'd127, 27'h7FFFFFC}, 32'h0, 8'h15, 32'h40000000, 3'b001, 2);
        drain("carry");
        run("ovf", 2'b00, {1'b0, 8'd254, 27'h7FFFFFC}, 32'h0, 8'h16, 32'h7F800000, 3'b011, 2);
        drain("ovf");
        run("zero", 2'b00, {1'b1, 8'd100, 27'd0}, 32'h0, 8'h17, 32'h80000000, 3'b000, 0);
        drain("zero");
        run("denorm", 2'b00, {1'b0, 8'd0, 27'h0000010}, 32'h0, 8'h18, 32'h00000002, 3'b000, 2);
        drain("denorm");
        run("den2norm", 2'b00, {1'b0, 8'd0, 27'h3FFFFFC}, 32'h0, 8'h19, 32'h00800000, 3'b001, 2);
        drain("den2norm");
        run("allign_fin", 2'b01, {1'b0, 8'd127, 27'h4000000}, 32'h0, 8'h1A, 32'h3F800000, 3'b000, 2);
        drain("allign_fin");
        run("tie_even", 2'b00, {1'b0, 8'd127, 27'h4000004}, 32'h0, 8'h1B, 32'h3F800000, 3'b001, 2);
        drain("tie_even");

        // Reset while still shifting abandons the result.
        @(negedge clock);
        idle_Pack   = 2'b00;
        zin_Pack    = {1'b0, 8'd130, 27'h0800000};
        InsTag_Pack = 8'h77;
        in_valid    = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_busy", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_zout", zout_Pack, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run("fresh", 2'b00, {1'b1, 8'd128, 27'h6000000}, 32'h0, 8'h3C, 32'hC0400000, 3'b000, 2);
        drain("fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
